// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Step-counter width for a given operand width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the datapath (master) and the divider (slave).
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             ovf;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, ovf
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, ovf
    );

endinterface

// File: rtl/seq_divider_step.sv
// One non-restoring iteration: shift the partial remainder, add or subtract D by its sign.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   p_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] d_ext;

    always_comb begin
        shifted = {p_i[WIDTH-1:0], q_msb_i};
        d_ext   = {1'b0, d_i};
        p_o     = p_i[WIDTH] ? (shifted + d_ext) : (shifted - d_ext);
        q_bit_o = ~p_o[WIDTH];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle WIDTH-bit divider with start/busy/done handshake.
// Signed support is built only when DIV_SIGNED_EN is defined.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_out_q, dz_out_d;

    logic [WIDTH:0]   step_p;
    logic             step_qb;
    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_fix, quo_fix;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovf_pend_q, ovf_pend_d;
    logic ovf_out_q, ovf_out_d;
`else
    logic unused_signed_op;
    assign unused_signed_op = bus.signed_op;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i     (p_q),
        .q_msb_i (q_q[WIDTH-1]),
        .d_i     (d_q),
        .p_o     (step_p),
        .q_bit_o (step_qb)
    );

    // Operand magnitudes; the algorithm itself only ever sees unsigned values.
    always_comb begin
`ifdef DIV_SIGNED_EN
        a_neg = bus.signed_op & bus.dividend[WIDTH-1];
        b_neg = bus.signed_op & bus.divisor[WIDTH-1];
        a_mag = a_neg ? -bus.dividend : bus.dividend;
        b_mag = b_neg ? -bus.divisor  : bus.divisor;
`else
        a_mag = bus.dividend;
        b_mag = bus.divisor;
`endif
    end

    // Final correction of a negative remainder, then sign application.
    always_comb begin
        rem_fix = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
        quo_fix = q_q;
`ifdef DIV_SIGNED_EN
        if (qneg_q) quo_fix = -quo_fix;
        if (rneg_q) rem_fix = -rem_fix;
`endif
        if (dz_q) quo_fix = '1;
    end

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        q_d      = q_q;
        d_d      = d_q;
        dz_d     = dz_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dz_out_d = dz_out_q;
`ifdef DIV_SIGNED_EN
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        ovf_pend_d = ovf_pend_q;
        ovf_out_d  = ovf_out_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                    p_d     = '0;
                    q_d     = a_mag;
                    d_d     = b_mag;
                    cnt_d   = CNT_W'(WIDTH);
                    dz_d    = (bus.divisor == '0);
`ifdef DIV_SIGNED_EN
                    qneg_d     = a_neg ^ b_neg;
                    rneg_d     = a_neg;
                    ovf_pend_d = bus.signed_op && (bus.dividend == MIN_VAL) &&
                                 (bus.divisor == '1);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d   = step_p;
                q_d   = {q_q[WIDTH-2:0], step_qb};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                state_d  = DONE;
                quo_d    = quo_fix;
                rem_d    = rem_fix;
                dz_out_d = dz_q;
`ifdef DIV_SIGNED_EN
                ovf_out_d = ovf_pend_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            dz_q     <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dz_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            q_q      <= q_d;
            d_q      <= d_d;
            dz_q     <= dz_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dz_out_q <= dz_out_d;
        end
    end

`ifdef DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_out_q  <= ovf_out_d;
        end
    end
    assign bus.ovf = ovf_out_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy        = (state_q == RUN) || (state_q == FIX);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, handshake/reset sequences, random vs model.
module tb_seq_divider;

    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ov;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ov;
    } res_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference from arithmetic rules, not from the algorithm.
    function automatic res_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        longint sa, sb;
        r.dz = 1'b0;
        r.ov = 1'b0;
        if (b == 32'd0) begin
            r.q  = 32'hFFFF_FFFF;
            r.r  = a;
            r.dz = 1'b1;
        end else if (s && SIGNED_EN) begin
            sa   = $signed(a);
            sb   = $signed(b);
            r.q  = 32'(sa / sb);
            r.r  = 32'(sa % sb);
            r.ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            r.q = a / b;
            r.r = a % b;
        end
        return r;
    endfunction

    // Caller is at a negedge; returns at the negedge after the start edge.
    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.signed_op = 1'($urandom_range(0, 1));
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    // Counts edges after the start edge until done; flags busy/done misbehaviour.
    task automatic wait_done(output int k, output bit hs_ok);
        k     = 0;
        hs_ok = bus.busy && !bus.done;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
            if (!bus.done && !bus.busy) hs_ok = 1'b0;
        end
        if (bus.busy) hs_ok = 1'b0;
    endtask

    task automatic check_res(input string tag, input res_t e);
        chk({tag, ".quotient"},  bus.quotient,    e.q);
        chk({tag, ".remainder"}, bus.remainder,   e.r);
        chk({tag, ".dz"},        bus.div_by_zero, e.dz);
        chk({tag, ".ovf"},       bus.ovf,         e.ov);
    endtask

    vec_t vecs[6];

    initial begin
        int   k;
        bit   hs;
        res_t e;
        bit   s;
        logic [31:0] a, b;

        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
        if (SIGNED_EN) begin
            vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
            vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1};
            vecs[5] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0};
        end else begin
            vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0};
            vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0};
            vecs[5] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0, 1'b0};
        end
        vecs[2] = '{1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        chk("reset.outputs",
            {bus.busy, bus.done, bus.div_by_zero, bus.ovf, bus.quotient, bus.remainder}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            @(negedge clk);
            launch(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(k, hs);
            chk($sformatf("vec%0d.latency", i), k, 33);
            chk($sformatf("vec%0d.handshake", i), hs, 1'b1);
            e = '{vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov};
            check_res($sformatf("vec%0d", i), e);
            @(negedge clk);
            chk($sformatf("vec%0d.done_pulse", i), {bus.done, bus.busy}, 2'b00);
        end

        // start pulsed mid-run is ignored
        launch(1'b0, 32'd1000, 32'd9);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        k = 5;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ignore_start.latency", k, 33);
        check_res("ignore_start", model(1'b0, 32'd1000, 32'd9));

        // Back-to-back: start held in the DONE cycle
        launch(1'b0, 32'd55, 32'd4);
        wait_done(k, hs);
        check_res("b2b_first", model(1'b0, 32'd55, 32'd4));
        launch(1'b0, 32'd1_000_003, 32'd17);
        wait_done(k, hs);
        chk("b2b_second.latency", k, 33);
        chk("b2b_second.handshake", hs, 1'b1);
        check_res("b2b_second", model(1'b0, 32'd1_000_003, 32'd17));

        // Reset asserted during RUN step 10
        @(negedge clk);
        launch(1'b0, 32'hDEAD_BEEF, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset.outputs",
            {bus.busy, bus.done, bus.div_by_zero, bus.ovf, bus.quotient, bus.remainder}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hs = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) hs = 1'b0;
        end
        chk("midreset.no_done", hs, 1'b1);
        launch(1'b0, 32'd9, 32'd3);
        wait_done(k, hs);
        chk("after_reset.latency", k, 33);
        check_res("after_reset", '{32'd3, 32'd0, 1'b0, 1'b0});

        // Randomized against the model
        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'($urandom_range(0, 20));
                1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            launch(s, a, b);
            wait_done(k, hs);
            chk($sformatf("rand%0d.latency", n), k, 33);
            check_res($sformatf("rand%0d", n), model(s, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
